// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM-stage load/store unit.
//
// Turns the EX/MEM memory request into one transaction on a registered
// data-memory bus, stalls the pipeline while it is outstanding, and formats
// load data for MEM/WB.
//
// Optional feature: define LSU_TIMEOUT_EN to add a WAIT-state watchdog. After
// 255 WAIT cycles without dmem_ready the access is abandoned, mem_read_data is
// cleared, and mem_bus_error pulses for one cycle. Without the macro there is
// no counter, no mem_bus_error port, and WAIT lasts until dmem_ready.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   exmem_ula_result    effective byte address
//   exmem_rs2_data      store data
//   exmem_funct3        size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU,
//                       011/110/111 treated as word)
//   exmem_MemRead/Write access request (both high -> store)
//   mem_read_data       formatted load result (registered, held)
//   mem_stall           pipeline freeze
//   mem_misaligned      fault pulse for a misaligned access (no bus request)
//   dmem_*              registered data-memory request bus, dmem_ready/rdata in
//   mem_bus_error       (LSU_TIMEOUT_EN only) watchdog expiry pulse
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// Memory handshake: dmem_req is a valid that rises in WAIT and stays high with
// addr/wdata/wstrb/we frozen until the cycle dmem_ready is sampled high at a
// rising clk edge; that edge completes the transfer and dmem_req drops on the
// next cycle. dmem_ready is ignored whenever dmem_req is low.

module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exmem_ula_result,
  input  logic [31:0] exmem_rs2_data,
  input  logic [2:0]  exmem_funct3,
  input  logic        exmem_MemRead,
  input  logic        exmem_MemWrite,
  output logic [31:0] mem_read_data,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
`ifdef LSU_TIMEOUT_EN
  output logic        mem_bus_error,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  ld_funct3;   // funct3 of the in-flight access, for load formatting

  logic        access;
  logic        aligned;
  logic        issue;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]  to_cnt;
`endif

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign access = exmem_MemRead | exmem_MemWrite;

  always_comb begin
    aligned = 1'b1;
    case (exmem_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~exmem_ula_result[0];
      default: aligned = (exmem_ula_result[1:0] == 2'b00);
    endcase
  end

  assign issue = access & aligned;

  // Combinational so the stall is visible in the same cycle the access arrives.
  assign mem_stall      = rst & (((state == IDLE) & issue) | (state == WAIT));
  assign mem_misaligned = rst & (state == IDLE) & access & ~aligned;

  // Store lane steering: data replicated on every lane, strobes pick the lanes.
  always_comb begin
    st_wdata = exmem_rs2_data;
    st_wstrb = 4'b1111;
    case (exmem_funct3[1:0])
      2'b00: begin
        st_wdata = {4{exmem_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << exmem_ula_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{exmem_rs2_data[15:0]}};
        st_wstrb = exmem_ula_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = exmem_rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction from the registered address of the in-flight access.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (dmem_addr[1:0])
      2'b00: ld_byte = dmem_rdata[7:0];
      2'b01: ld_byte = dmem_rdata[15:8];
      2'b10: ld_byte = dmem_rdata[23:16];
      2'b11: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = dmem_rdata;
    case (ld_funct3[1:0])
      2'b00:   ld_data = ld_funct3[2] ? {24'b0, ld_byte}
                                      : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = ld_funct3[2] ? {16'b0, ld_half}
                                      : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and registered bus
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_wstrb    <= 4'h0;
      mem_read_data <= 32'h0;
      ld_funct3     <= 3'b000;
`ifdef LSU_TIMEOUT_EN
      to_cnt        <= 8'h0;
      mem_bus_error <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      mem_bus_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= exmem_MemWrite;
            dmem_addr  <= exmem_ula_result;
            dmem_wdata <= exmem_MemWrite ? st_wdata : 32'h0;
            dmem_wstrb <= exmem_MemWrite ? st_wstrb : 4'h0;
            ld_funct3  <= exmem_funct3;
`ifdef LSU_TIMEOUT_EN
            to_cnt     <= 8'h0;
`endif
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            // A store (including read+write) leaves the load result untouched.
            if (!dmem_we) mem_read_data <= ld_data;
          end
`ifdef LSU_TIMEOUT_EN
          // 254 means this is the 255th cycle without a response.
          else if (to_cnt == 8'd254) begin
            state         <= DONE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            mem_read_data <= 32'h0;
            mem_bus_error <= 1'b1;
            to_cnt        <= 8'd255;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          // One non-stalled cycle lets the pipeline move past this instruction
          // so it is not issued a second time.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu (default build; the watchdog test is
// compiled only when LSU_TIMEOUT_EN is defined).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exmem_ula_result, exmem_rs2_data;
  logic [2:0]  exmem_funct3;
  logic        exmem_MemRead, exmem_MemWrite;
  logic [31:0] mem_read_data;
  logic        mem_stall, mem_misaligned;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [1:0]  dbg_state;
`ifdef LSU_TIMEOUT_EN
  logic        mem_bus_error;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .exmem_ula_result (exmem_ula_result),
    .exmem_rs2_data   (exmem_rs2_data),
    .exmem_funct3     (exmem_funct3),
    .exmem_MemRead    (exmem_MemRead),
    .exmem_MemWrite   (exmem_MemWrite),
    .mem_read_data    (mem_read_data),
    .mem_stall        (mem_stall),
    .mem_misaligned   (mem_misaligned),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wstrb       (dmem_wstrb),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
`ifdef LSU_TIMEOUT_EN
    .mem_bus_error    (mem_bus_error),
`endif
    .dbg_state        (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [2:0] f3);
    exmem_MemRead    = rd;
    exmem_MemWrite   = wr;
    exmem_ula_result = addr;
    exmem_rs2_data   = data;
    exmem_funct3     = f3;
  endtask

  task automatic clear_inputs();
    set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  // Presents one EX/MEM instruction (called just after a rising edge), answers
  // the memory after 'delay' WAIT cycles and records what the DUT did.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3,
                        input logic [31:0] rdata, input int delay,
                        output int stall_cyc, output int req_cyc, output int mis_cyc,
                        output logic done_ok, output logic [31:0] q_addr,
                        output logic [31:0] q_wdata, output logic [3:0] q_wstrb,
                        output logic q_we, output logic [31:0] rd_result);
    int   wait_cnt;
    logic last_stall;
    stall_cyc = 0; req_cyc = 0; mis_cyc = 0; done_ok = 1'b0; wait_cnt = 0;
    q_addr = 'x; q_wdata = 'x; q_wstrb = 'x; q_we = 1'bx; rd_result = 'x;
    set_inputs(rd, wr, addr, data, f3);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      last_stall = mem_stall;
      if (mem_stall) stall_cyc++;
      if (mem_misaligned) mis_cyc++;
      if (dmem_req) begin
        req_cyc++;
        q_addr = dmem_addr; q_wdata = dmem_wdata; q_wstrb = dmem_wstrb; q_we = dmem_we;
        if (wait_cnt >= delay) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdata;
        end
        wait_cnt++;
      end
      if (dbg_state == ST_DONE) begin
        done_ok   = 1'b1;
        rd_result = mem_read_data;
      end
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      if (done_ok || !last_stall) break;
    end
    clear_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_inputs(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_req_we: got %b%b expected 00", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_bus: got addr %h wdata %h wstrb %b expected zeros", dmem_addr, dmem_wdata, dmem_wstrb); end
    checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_read_data); end
    exmem_ula_result = 32'h101;
    #1;
    checks++; if (mem_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", mem_misaligned); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_lw();
    int s, r, m; logic ok, we; logic [31:0] a, wd, res; logic [3:0] ws;
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 0, s, r, m, ok, a, wd, ws, we, res);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lw_done: got %b expected 1", ok); end
    checks++; if (s != 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d expected 2", s); end
    checks++; if (r != 1) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 1", r); end
    checks++; if (a !== 32'h100 || we !== 1'b0) begin errors++; $display("FAIL lw_bus: got addr %h we %b expected 100 0", a, we); end
    checks++; if (res !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", res); end
    last_load = 32'hDEADBEEF;
    // Non-memory instruction passes in one cycle with no stall.
    run_op(1'b0, 1'b0, 32'h104, 32'h0, 3'b010, 32'h0, 0, s, r, m, ok, a, wd, ws, we, res);
    checks++; if (s != 0 || r != 0) begin errors++; $display("FAIL nonmem: got stall %0d req %0d expected 0 0", s, r); end
    checks++; if (mem_read_data !== last_load) begin errors++; $display("FAIL nonmem_hold: got %h expected %h", mem_read_data, last_load); end
  endtask

  task automatic test_load_format();
    logic [31:0] addrs [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h10C};
    logic [2:0]  f3s   [7] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001, 3'b000, 3'b011};
    logic [31:0] rds   [7] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                               32'h80FF1234, 32'h80FF1234, 32'h13572468};
    logic [31:0] exps  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                               32'h00001234, 32'h00000012, 32'h13572468};
    int s, r, m; logic ok, we; logic [31:0] a, wd, res; logic [3:0] ws;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b1, 1'b0, addrs[i], 32'h0, f3s[i], rds[i], 0, s, r, m, ok, a, wd, ws, we, res);
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL load_fmt[%0d]: got %h expected %h", i, res, exps[i]); end
      checks++; if (a !== addrs[i] || s != 2) begin errors++; $display("FAIL load_bus[%0d]: got addr %h stall %0d expected %h 2", i, a, s, addrs[i]); end
    end
    last_load = 32'h13572468;
  endtask

  task automatic test_store();
    logic [31:0] addrs [5] = '{32'h202, 32'h201, 32'h200, 32'h204, 32'h208};
    logic [2:0]  f3s   [5] = '{3'b001, 3'b000, 3'b001, 3'b010, 3'b111};
    logic [31:0] dats  [5] = '{32'h0000ABCD, 32'h12345678, 32'h0000ABCD, 32'hCAFEF00D, 32'hCAFEF00D};
    logic [3:0]  strbs [5] = '{4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b1111};
    logic [31:0] wds   [5] = '{32'hABCDABCD, 32'h78787878, 32'hABCDABCD, 32'hCAFEF00D, 32'hCAFEF00D};
    int s, r, m; logic ok, we; logic [31:0] a, wd, res; logic [3:0] ws;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, 1'b1, addrs[i], dats[i], f3s[i], 32'h55555555, 0, s, r, m, ok, a, wd, ws, we, res);
      checks++; if (we !== 1'b1 || ws !== strbs[i] || wd !== wds[i] || a !== addrs[i]) begin
        errors++; $display("FAIL store[%0d]: got we %b wstrb %b wdata %h addr %h expected 1 %b %h %h",
                           i, we, ws, wd, a, strbs[i], wds[i], addrs[i]); end
      checks++; if (res !== last_load) begin errors++; $display("FAIL store_hold[%0d]: got %h expected %h", i, res, last_load); end
    end
    // Read and write together behaves as a store.
    run_op(1'b1, 1'b1, 32'h210, 32'h11223344, 3'b010, 32'h55555555, 0, s, r, m, ok, a, wd, ws, we, res);
    checks++; if (we !== 1'b1 || ws !== 4'b1111 || wd !== 32'h11223344) begin
      errors++; $display("FAIL rw_store: got we %b wstrb %b wdata %h expected 1 1111 11223344", we, ws, wd); end
    checks++; if (res !== last_load) begin errors++; $display("FAIL rw_hold: got %h expected %h", res, last_load); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [4] = '{32'h101, 32'h203, 32'h102, 32'h201};
    logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b110, 3'b101};
    logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int s, r, m; logic ok, we; logic [31:0] a, wd, res; logic [3:0] ws;
    for (int i = 0; i < 4; i++) begin
      run_op(~wrs[i], wrs[i], addrs[i], 32'h0, f3s[i], 32'h0, 0, s, r, m, ok, a, wd, ws, we, res);
      checks++; if (m != 1 || s != 0 || r != 0) begin
        errors++; $display("FAIL misaligned[%0d]: got mis %0d stall %0d req %0d expected 1 0 0", i, m, s, r); end
    end
    @(negedge clk);
    checks++; if (mem_misaligned !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL misaligned_after: got mis %b state %0d expected 0 0", mem_misaligned, dbg_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_delayed();
    int s, r, m; logic ok, we; logic [31:0] a, wd, res; logic [3:0] ws;
    run_op(1'b1, 1'b0, 32'h120, 32'h0, 3'b010, 32'h0BADF00D, 3, s, r, m, ok, a, wd, ws, we, res);
    checks++; if (s != 5 || r != 4) begin errors++; $display("FAIL delayed_cycles: got stall %0d req %0d expected 5 4", s, r); end
    checks++; if (res !== 32'h0BADF00D) begin errors++; $display("FAIL delayed_data: got %h expected 0badf00d", res); end
    last_load = 32'h0BADF00D;
  endtask

  task automatic test_reset_in_wait();
    set_inputs(1'b1, 1'b0, 32'h300, 32'h0, 3'b010);
    dmem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (dbg_state !== ST_WAIT || dmem_req !== 1'b1) begin
      errors++; $display("FAIL rw_wait3: got state %0d req %b expected 1 1", dbg_state, dmem_req); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_in_wait_stall: got %b expected 0", mem_stall); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rst_in_wait_req: got req %b state %0d expected 0 0", dmem_req, dbg_state); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0 || dmem_we !== 1'b0 || mem_read_data !== 32'h0) begin
      errors++; $display("FAIL rst_in_wait_vals: got addr %h wdata %h wstrb %b we %b rdata %h expected zeros",
                         dmem_addr, dmem_wdata, dmem_wstrb, dmem_we, mem_read_data); end
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE || mem_read_data !== 32'h0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL late_ready: got state %0d rdata %h req %b expected 0 0 0", dbg_state, mem_read_data, dmem_req); end
    @(posedge clk); #1;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int wait_cyc; logic seen_done;
    wait_cyc = 0; seen_done = 1'b0;
    set_inputs(1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
    dmem_ready = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (dbg_state == ST_WAIT) wait_cyc++;
      if (dbg_state == ST_DONE) begin seen_done = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (seen_done !== 1'b1 || wait_cyc != 255) begin
      errors++; $display("FAIL timeout_cycles: got done %b wait %0d expected 1 255", seen_done, wait_cyc); end
    checks++; if (mem_bus_error !== 1'b1 || mem_read_data !== 32'h0) begin
      errors++; $display("FAIL timeout_err: got err %b rdata %h expected 1 0", mem_bus_error, mem_read_data); end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    checks++; if (mem_bus_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b expected 0", mem_bus_error); end
    @(posedge clk); #1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    last_load = 32'h0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_lw();
    test_load_format();
    test_store();
    test_misaligned();
    test_delayed();
    test_reset_in_wait();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
